// File: rtl/neuron_lane_array_if.sv
// Controller/memory to neuron bank link: segment control, operand
// beats, lane select and the result/status path back.
interface neuron_lane_array_if #(
  parameter int N_LANES = 10,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10
);
  logic                      head_c2node;
  logic [LEN_W-1:0]          len_c2node;
  logic                      bias_en_c2node;
  logic                      relu_en_c2node;
  logic                      in_valid_mem2node;
  logic [DATA_W-1:0]         x_data_mem2node;
  logic [N_LANES*DATA_W-1:0] w_data_mem2node;
  logic [N_LANES*DATA_W-1:0] b_data_mem2node;
  logic [3:0]                data_select_c2node;
  logic                      done_flag_node2c;
  logic                      busy_node2c;
  logic [DATA_W-1:0]         data_node2mem;

  modport master (
    output head_c2node, len_c2node,
    output bias_en_c2node, relu_en_c2node,
    output in_valid_mem2node, x_data_mem2node,
    output w_data_mem2node, b_data_mem2node,
    output data_select_c2node,
    input  done_flag_node2c, busy_node2c,
    input  data_node2mem
  );

  modport slave (
    input  head_c2node, len_c2node,
    input  bias_en_c2node, relu_en_c2node,
    input  in_valid_mem2node, x_data_mem2node,
    input  w_data_mem2node, b_data_mem2node,
    input  data_select_c2node,
    output done_flag_node2c, busy_node2c,
    output data_node2mem
  );
endinterface

// File: rtl/neuron_lane_array.sv
// Ten-lane MAC neuron bank: streamed x times per-lane weights,
// optional bias and ReLU, saturated Q8.8 results muxed out by lane.
module neuron_lane_array #(
  parameter int N_LANES = 10,
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  parameter int LEN_W   = 10
) (
  input  logic               clock,
  input  logic               rst,
  neuron_lane_array_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    DONE
  } state_e;

  localparam int PW = 2 * DATA_W;
  localparam int XW = ACC_W + 1 - DATA_W;
  localparam logic [3:0] SEL_LIM = 4'(N_LANES);

  localparam logic signed [ACC_W:0] SAT_HI =
    {{(XW + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO =
    {{(XW + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q [N_LANES];
  logic signed [ACC_W-1:0] acc_d [N_LANES];
  logic [DATA_W-1:0]       res_q [N_LANES];
  logic [DATA_W-1:0]       res_d [N_LANES];
  logic [DATA_W-1:0]       fin   [N_LANES];

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_inc;
  logic bias_q, bias_d;
  logic relu_q, relu_d;
  logic done_q, done_d;

  // Finish math: floor shift, optional bias, clamp, then ReLU.
  always_comb begin
    logic signed [ACC_W-1:0] sh;
    logic signed [ACC_W:0]   s;
    logic [DATA_W-1:0]       b;
    sh = '0;
    s  = '0;
    b  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      sh = acc_q[i] >>> FRAC;
      b  = bus.b_data_mem2node[i*DATA_W +: DATA_W];
      s  = {sh[ACC_W-1], sh}
         + (bias_q ? {{XW{b[DATA_W-1]}}, b} : '0);
      fin[i] = s[DATA_W-1:0];
      if (s > SAT_HI) fin[i] = SAT_HI[DATA_W-1:0];
      else if (s < SAT_LO) fin[i] = SAT_LO[DATA_W-1:0];
      if (relu_q && fin[i][DATA_W-1]) fin[i] = '0;
    end
  end

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic signed [PW-1:0]     p;
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    bias_d  = bias_q;
    relu_d  = relu_q;
    done_d  = done_q;
    x = bus.x_data_mem2node;
    w = '0;
    p = '0;
    if (bus.head_c2node) begin
      for (int i = 0; i < N_LANES; i++) acc_d[i] = '0;
      cnt_d   = '0;
      len_d   = bus.len_c2node;
      bias_d  = bus.bias_en_c2node;
      relu_d  = bus.relu_en_c2node;
      done_d  = 1'b0;
      state_d = (bus.len_c2node == '0) ? FINISH : ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (bus.in_valid_mem2node) begin
            for (int i = 0; i < N_LANES; i++) begin
              w = bus.w_data_mem2node[i*DATA_W +: DATA_W];
              p = x * w;
              acc_d[i] = acc_q[i]
                       + {{(ACC_W - PW){p[PW-1]}}, p};
            end
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = FINISH;
          end
        end
        FINISH: begin
          res_d   = fin;
          done_d  = 1'b1;
          state_d = DONE;
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < N_LANES; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
      cnt_q  <= '0;
      len_q  <= '0;
      bias_q <= 1'b0;
      relu_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bias_q  <= bias_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.data_node2mem = '0;
    if (bus.data_select_c2node < SEL_LIM)
      bus.data_node2mem = res_q[bus.data_select_c2node];
  end

  assign bus.done_flag_node2c = done_q;
  assign bus.busy_node2c =
    (state_q == ACCUM) || (state_q == FINISH);

endmodule

// File: tb/tb_neuron_lane_array.sv
// Randomized and directed bench for neuron_lane_array against an
// integer-arithmetic reference model of each lane.
module tb_neuron_lane_array;

  localparam int NL = 10;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic rst;
  always #50 clock = ~clock;

  neuron_lane_array_if bus ();

  neuron_lane_array dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  longint      macc [NL];
  logic [15:0] prev [NL];
  logic [15:0] cur  [NL];
  logic [15:0] zero [NL];
  logic [15:0]         dx;
  logic [NL*DW-1:0]    dw;
  logic [NL*DW-1:0]    db;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] exp_lane(longint acc,
      logic [15:0] b, bit bias, bit relu);
    longint s;
    s = (acc >>> 8) + (bias ? longint'($signed(b)) : 64'sd0);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic sel_chk(string tag, int s, logic [15:0] e);
    bus.data_select_c2node = 4'(s);
    #1;
    chk(tag, 64'(bus.data_node2mem), 64'(e));
  endtask

  task automatic read_all(string tag, input logic [15:0] e [NL]);
    for (int s = 0; s < 16; s++) begin
      bus.data_select_c2node = 4'(s);
      #1;
      chk(tag, 64'(bus.data_node2mem),
          (s < NL) ? 64'(e[s]) : 64'd0);
    end
  endtask

  task automatic gen_beat(int mode);
    dx = 16'($urandom);
    if ($urandom_range(0, 1) == 1) dx = {{8{dx[7]}}, dx[7:0]};
    for (int i = 0; i < NL; i++) dw[i*DW +: DW] = 16'($urandom);
    if (mode == 1) begin
      dx = 16'h0100;
      dw[15:0]  = 16'h0200;
      dw[31:16] = 16'hFF00;
    end else if (mode == 2) begin
      dx = 16'h7FFF;
      dw[15:0]  = 16'h7FFF;
      dw[31:16] = 16'h8001;
    end
  endtask

  task automatic run_seg(int len, bit bias, bit relu,
                         int mode, int gap, bit hv);
    for (int i = 0; i < NL; i++) macc[i] = 0;
    gen_beat(0);
    bus.head_c2node       = 1'b1;
    bus.len_c2node        = 10'(len);
    bus.bias_en_c2node    = bias;
    bus.relu_en_c2node    = relu;
    bus.in_valid_mem2node = hv;
    bus.x_data_mem2node   = 16'h0100;
    bus.w_data_mem2node   = dw;
    bus.b_data_mem2node   = db;
    step();
    bus.head_c2node       = 1'b0;
    bus.in_valid_mem2node = 1'b0;
    chk("head_done_clr", 64'(bus.done_flag_node2c), 64'd0);
    chk("head_busy", 64'(bus.busy_node2c), 64'd1);
    for (int k = 0; k < len; k++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_done", 64'(bus.done_flag_node2c), 64'd0);
      end
      gen_beat(mode);
      bus.x_data_mem2node   = dx;
      bus.w_data_mem2node   = dw;
      bus.in_valid_mem2node = 1'b1;
      for (int i = 0; i < NL; i++)
        macc[i] += longint'($signed(dx))
                 * longint'($signed(dw[i*DW +: DW]));
      step();
      bus.in_valid_mem2node = 1'b0;
      if (k == len - 1)
        chk("lat_pre", 64'(bus.done_flag_node2c), 64'd0);
    end
    read_all("held", prev);
    step();
    chk("done", 64'(bus.done_flag_node2c), 64'd1);
    chk("done_busy", 64'(bus.busy_node2c), 64'd0);
    for (int i = 0; i < NL; i++)
      cur[i] = exp_lane(macc[i], db[i*DW +: DW], bias, relu);
    read_all("lane", cur);
    bus.in_valid_mem2node = 1'b1;
    bus.x_data_mem2node   = 16'h7FFF;
    step();
    bus.in_valid_mem2node = 1'b0;
    chk("done_hold", 64'(bus.done_flag_node2c), 64'd1);
    sel_chk("done_ignore", 0, cur[0]);
    prev = cur;
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      zero[i] = '0;
      prev[i] = '0;
    end
    rst = 1'b1;
    bus.head_c2node        = 1'b0;
    bus.len_c2node         = '0;
    bus.bias_en_c2node     = 1'b0;
    bus.relu_en_c2node     = 1'b0;
    bus.in_valid_mem2node  = 1'b0;
    bus.x_data_mem2node    = '0;
    bus.w_data_mem2node    = '0;
    bus.b_data_mem2node    = '0;
    bus.data_select_c2node = '0;
    db = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_done", 64'(bus.done_flag_node2c), 64'd0);
    chk("rst_busy", 64'(bus.busy_node2c), 64'd0);
    read_all("rst_lane", zero);

    db = '0;
    db[15:0] = 16'h0080;
    run_seg(3, 1, 0, 1, 0, 0);
    sel_chk("basic_l0", 0, 16'h0680);
    sel_chk("basic_l1", 1, 16'hFD00);

    run_seg(3, 1, 1, 1, 0, 0);
    sel_chk("relu_l1", 1, 16'h0000);
    sel_chk("relu_l0", 0, 16'h0680);
    sel_chk("relu_sel10", 10, 16'h0000);

    db = '0;
    run_seg(4, 0, 0, 2, 0, 0);
    sel_chk("sat_hi", 0, 16'h7FFF);
    sel_chk("sat_lo", 1, 16'h8000);

    run_seg(2, 0, 0, 0, 3, 0);
    run_seg(2, 0, 0, 0, 0, 1);

    db = '0;
    db[15:0] = 16'h0123;
    run_seg(0, 1, 0, 0, 0, 0);
    sel_chk("zero_len", 0, 16'h0123);

    bus.head_c2node    = 1'b1;
    bus.len_c2node     = 10'd5;
    bus.bias_en_c2node = 1'b0;
    bus.relu_en_c2node = 1'b0;
    step();
    bus.head_c2node       = 1'b0;
    bus.in_valid_mem2node = 1'b1;
    bus.x_data_mem2node   = 16'h0300;
    step();
    step();
    bus.in_valid_mem2node = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_done", 64'(bus.done_flag_node2c), 64'd0);
    chk("abort_busy", 64'(bus.busy_node2c), 64'd0);
    prev = zero;
    read_all("abort_lane", zero);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NL; i++) db[i*DW +: DW] = 16'($urandom);
      run_seg($urandom_range(0, 6), 1'($urandom),
              1'($urandom), 0, $urandom_range(0, 2),
              1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
